// File: rtl/pe_acc_drain.sv
// Systolic-array PE: forwards operands, accumulates a K-beat signed dot product, then
// rounds/saturates the result and shifts it out through a daisy-chained drain path.
module pe_acc_drain #(
  parameter int unsigned D_W    = 16,
  parameter int unsigned FRAC_W = 13,
  parameter int unsigned ACC_W  = 40,
  parameter int unsigned KW     = 8,
  parameter int unsigned RND    = 1
) (
  input  logic           I_CLK,
  input  logic           I_ASYN_RSTN,
  input  logic           I_SYNC_RSTN,
  input  logic           I_VLD,
  input  logic [D_W-1:0] I_X,
  input  logic [D_W-1:0] I_W,
  input  logic [KW-1:0]  I_K,
  input  logic           I_SHIFT,
  input  logic [D_W-1:0] I_D,
  input  logic           I_D_VLD,
  output logic           O_VLD,
  output logic [D_W-1:0] O_X,
  output logic [D_W-1:0] O_W,
  output logic [D_W-1:0] O_D,
  output logic           O_D_VLD,
  output logic           O_BUSY,
  output logic           O_DONE,
  output logic           O_OVF
);

  typedef enum logic [1:0] {StIdle, StAcc, StRdy, StFwd} state_e;

  localparam logic [ACC_W:0] Half =
      (RND != 0) ? ((ACC_W + 1)'(1) << (FRAC_W - 1)) : '0;
  localparam logic signed [ACC_W:0] SatMax = {{(ACC_W - D_W + 2){1'b0}}, {(D_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SatMin = {{(ACC_W - D_W + 2){1'b1}}, {(D_W - 1){1'b0}}};

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [KW-1:0]            cnt_q, cnt_d, k_q, k_d;
  logic [D_W-1:0]           res_q, res_d;
  logic                     ovf_q, ovf_d;
  logic                     vld_q, vld_d;
  logic [D_W-1:0]           x_q, x_d, w_q, w_d, d_q, d_d;
  logic                     d_vld_q, d_vld_d;

  logic signed [2*D_W-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext, acc_sum;
  logic signed [ACC_W:0]    rnd_sum, shifted;
  logic [D_W-1:0]           sat_res;
  logic                     clamp, load_res;
  logic [KW-1:0]            k_in, cnt_inc;

  assign prod     = $signed(I_X) * $signed(I_W);
  assign prod_ext = {{(ACC_W - 2 * D_W){prod[2*D_W-1]}}, prod};
  assign acc_sum  = (state_q == StIdle) ? prod_ext : acc_q + prod_ext;
  assign k_in     = (I_K == '0) ? KW'(1) : I_K;
  assign cnt_inc  = cnt_q + KW'(1);

  // Round and saturate the post-beat accumulator so the result loads with the last beat.
  always_comb begin
    rnd_sum = $signed({acc_sum[ACC_W-1], acc_sum} + Half);
    shifted = rnd_sum >>> FRAC_W;
    clamp   = 1'b0;
    sat_res = shifted[D_W-1:0];
    if (shifted > SatMax) begin
      sat_res = {1'b0, {(D_W - 1){1'b1}}};
      clamp   = 1'b1;
    end else if (shifted < SatMin) begin
      sat_res = {1'b1, {(D_W - 1){1'b0}}};
      clamp   = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    vld_d    = I_VLD;
    x_d      = I_VLD ? I_X : x_q;
    w_d      = I_VLD ? I_W : w_q;
    d_d      = d_q;
    d_vld_d  = 1'b0;
    load_res = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (I_VLD) begin
          acc_d = acc_sum;
          cnt_d = KW'(1);
          k_d   = k_in;
          ovf_d = 1'b0;
          if (k_in == KW'(1)) begin
            state_d  = StRdy;
            load_res = 1'b1;
          end else begin
            state_d = StAcc;
          end
        end
        if (I_SHIFT) begin
          d_d     = I_D;
          d_vld_d = I_D_VLD;
        end
      end
      StAcc: begin
        if (I_VLD) begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
          if (cnt_inc == k_q) begin
            state_d  = StRdy;
            load_res = 1'b1;
          end
        end
        if (I_SHIFT) begin
          d_d     = I_D;
          d_vld_d = I_D_VLD;
        end
      end
      StRdy: begin
        if (I_SHIFT) begin
          d_d     = res_q;
          d_vld_d = 1'b1;
          state_d = StFwd;
        end
      end
      StFwd: begin
        if (I_SHIFT) begin
          d_d     = I_D;
          d_vld_d = I_D_VLD;
        end else begin
          state_d = StIdle;
        end
      end
    endcase

    if (load_res) begin
      res_d = sat_res;
      ovf_d = clamp;
    end

    // Synchronous reset overrides everything, even mid-job or mid-drain.
    if (!I_SYNC_RSTN) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
      k_d     = '0;
      res_d   = '0;
      ovf_d   = 1'b0;
      vld_d   = 1'b0;
      x_d     = '0;
      w_d     = '0;
      d_d     = '0;
      d_vld_d = 1'b0;
    end
  end

  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      x_q     <= '0;
      w_q     <= '0;
      d_q     <= '0;
      d_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      x_q     <= x_d;
      w_q     <= w_d;
      d_q     <= d_d;
      d_vld_q <= d_vld_d;
    end
  end

  assign O_VLD   = vld_q;
  assign O_X     = x_q;
  assign O_W     = w_q;
  assign O_D     = d_q;
  assign O_D_VLD = d_vld_q;
  assign O_BUSY  = (state_q == StAcc);
  assign O_DONE  = (state_q == StRdy);
  assign O_OVF   = ovf_q;

endmodule

// File: doc/pe_acc_drain.md
PE_ACC_DRAIN -- requirements
Module: pe_acc_drain

Interface
REQ-001 SHALL have parameter D_W, default 16, meaning operand and result width (signed two's complement).
REQ-002 SHALL have parameter FRAC_W, default 13, meaning fraction bits of operands and result.
REQ-003 SHALL have parameter ACC_W, default 40, meaning accumulator width; ACC_W >= 2*D_W+KW is required.
REQ-004 SHALL have parameter KW, default 8, meaning width of the dot-product length input.
REQ-005 SHALL have parameter RND, default 1, meaning result rounding: 0 = truncate, 1 = round-half-up.
REQ-006 SHALL have I_CLK, in, 1: clock; all state changes on its rising edge.
REQ-007 SHALL have I_ASYN_RSTN, in, 1: reset, asynchronous, active-low.
REQ-008 SHALL have I_SYNC_RSTN, in, 1: synchronous reset, active-low.
REQ-009 SHALL have I_VLD, in, 1: I_X/I_W beat valid.
REQ-010 SHALL have I_X, in, D_W: activation from left; I_W, in, D_W: weight from above.
REQ-011 SHALL have I_K, in, KW: dot-product length, sampled on the first beat of a job.
REQ-012 SHALL have I_SHIFT, in, 1: drain-chain shift enable; I_D, in, D_W and I_D_VLD, in, 1: drain data from the upstream PE.
REQ-013 SHALL have O_VLD, out, 1; O_X, out, D_W; O_W, out, D_W: registered forwarded operands.
REQ-014 SHALL have O_D, out, D_W and O_D_VLD, out, 1: drain-chain output.
REQ-015 SHALL have O_BUSY, out, 1 (state ACC); O_DONE, out, 1 (state RDY); O_OVF, out, 1 (sticky saturation flag of the current job).

Function
REQ-016 SHALL forward I_X/I_W to O_X/O_W with 1-cycle latency when I_VLD=1 in any state; O_X/O_W SHALL hold when I_VLD=0; O_VLD SHALL equal I_VLD delayed 1 cycle.
REQ-017 SHALL form the full signed 2*D_W-bit product I_X*I_W, sign-extend it to ACC_W, and accumulate it without intermediate truncation.
REQ-018 SHALL implement states IDLE, ACC, RDY, FWD.
REQ-019 IDLE + I_VLD: acc := product, cnt := 1, K := max(I_K,1), O_OVF := 0; next state RDY if K=1, else ACC.
REQ-020 ACC + I_VLD: acc += product, cnt += 1; when cnt+1 = K, next state RDY and the result register loads; ACC with I_VLD=0 holds.
REQ-021 The result SHALL be (acc + (RND ? 2^(FRAC_W-1) : 0)) >>> FRAC_W, saturated to [-2^(D_W-1), 2^(D_W-1)-1]; O_OVF SHALL be set when clamping occurs.
REQ-022 I_VLD in RDY/FWD SHALL forward operands only and SHALL NOT modify acc, cnt or the result.
REQ-023 RDY + I_SHIFT: O_D := result, O_D_VLD := 1, next state FWD; RDY with I_SHIFT=0 holds, O_D_VLD := 0.
REQ-024 FWD + I_SHIFT: O_D := I_D, O_D_VLD := I_D_VLD; FWD with I_SHIFT=0: O_D_VLD := 0, next state IDLE.
REQ-025 In IDLE/ACC, I_SHIFT=1 SHALL forward I_D/I_D_VLD to O_D/O_D_VLD (pass-through for a chain whose downstream PEs are not ready); otherwise O_D_VLD := 0 and O_D holds.
REQ-026 O_DONE SHALL be high from the cycle after the last beat until the cycle in which RDY leaves on I_SHIFT.

Reset
REQ-027 I_ASYN_RSTN=0 SHALL immediately clear all outputs, acc, cnt, K and the result, and set the state to IDLE.
REQ-028 I_SYNC_RSTN=0 at a clock edge SHALL produce the same effect, with priority over every other input, including mid-job or mid-drain.

Verification
REQ-029 D_W=16, FRAC_W=13, K=4, X=0x2000, W=0x1000 for 4 beats -> O_DONE is 1 cycle after the 4th beat; after I_SHIFT, O_D=0x4000 and O_OVF=0.
REQ-030 K=2, X=W=0x7FFF twice -> O_D=0x7FFF, O_OVF=1; K=1, X=0x8000, W=0x7FFF -> O_D=0x8000, O_OVF=1.
REQ-031 K=1, X=0x0001, W=0x1000 -> O_D=0x0001 with RND=1, and 0x0000 with RND=0.
REQ-032 Two chained PEs, both in RDY with results 0x0111 and 0x0222, and I_SHIFT held for 2 cycles -> downstream O_D emits 0x0222 then 0x0111, each with O_D_VLD=1; both PEs then return to IDLE.
REQ-033 K=4 with I_VLD gaps between beats, then I_SYNC_RSTN pulsed after the 2nd beat -> all outputs 0 and state IDLE; a new K=1 job then completes correctly with O_OVF=0.
REQ-034 I_K=0 with 1 beat -> behaves as K=1; I_VLD in RDY -> operands are forwarded and the result is unchanged.
